// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_PROBE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

  // Number of bitstream words needed to cover a chain of the given length.
  function automatic int words_for_bits(input int bits, input int word_w);
    return (bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Two-entry word buffer that turns a ready/valid word stream into a bit
// stream, LSB first. The second entry lets the next word arrive while the
// current one is still being shifted, so consecutive words leave no gap.
module ccff_word_serializer #(
  parameter int WORD_W  = 8,
  parameter int N_WORDS = 4
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              shift_i,
  input  logic              s_valid_i,
  input  logic [WORD_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              bit_valid_o,
  output logic              bit_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WC_W  = $clog2(N_WORDS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WC_W-1:0]  WC_MAX   = WC_W'(N_WORDS);
  localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);

  logic              cur_vld_q, cur_vld_d;
  logic              nxt_vld_q, nxt_vld_d;
  logic [WORD_W-1:0] cur_q, cur_d;
  logic [WORD_W-1:0] nxt_q, nxt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              accept;
  logic              pop;

  // Handshake, bit output and end-of-word detection.
  always_comb begin
    s_ready_o   = enable_i & ~nxt_vld_q & (wcnt_q < WC_MAX);
    accept      = s_valid_i & s_ready_o;
    pop         = shift_i & cur_vld_q & (idx_q == IDX_LAST);
    bit_valid_o = cur_vld_q;
    bit_o       = cur_q[idx_q];
  end

  // Buffer next-state: advance the bit index, refill the shift word on pop.
  always_comb begin
    cur_vld_d = cur_vld_q;
    nxt_vld_d = nxt_vld_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    if (shift_i && cur_vld_q) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end
    if (accept) begin
      wcnt_d = wcnt_q + WC_ONE;
    end
    if (pop) begin
      if (nxt_vld_q) begin
        cur_d     = nxt_q;
        nxt_vld_d = 1'b0;
      end else if (accept) begin
        cur_d = s_data_i;
      end else begin
        cur_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (cur_vld_q) begin
        nxt_d     = s_data_i;
        nxt_vld_d = 1'b1;
      end else begin
        cur_d     = s_data_i;
        cur_vld_d = 1'b1;
      end
    end
  end

  // Control state; clear empties the buffer and restarts the word count.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      idx_q     <= '0;
      wcnt_q    <= '0;
    end else begin
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Word storage; contents only matter while the matching valid flag is set.
  always_ff @(posedge clk_i) begin
    cur_q <= cur_d;
    nxt_q <= nxt_d;
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Drives a configuration chain head: flush with zeros, probe the chain
// length with a single marker bit, then load CHAIN_LEN bitstream bits.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;

  logic ser_en;
  logic ser_clear;
  logic ser_shift;
  logic ser_bit_valid;
  logic ser_bit;

  // The buffer only operates in LOAD; any other state discards its words.
  always_comb begin
    ser_en    = (state_q == ST_LOAD);
    ser_clear = prog_reset | ~ser_en;
    ser_shift = ser_en & ser_bit_valid;
  end

  ccff_word_serializer #(
    .WORD_W  (WORD_W),
    .N_WORDS (words_for_bits(CHAIN_LEN, WORD_W))
  ) u_ser (
    .clk_i       (prog_clk),
    .clear_i     (ser_clear),
    .enable_i    (ser_en),
    .shift_i     (ser_shift),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready),
    .bit_valid_o (ser_bit_valid),
    .bit_o       (ser_bit)
  );

  // State, shift counter and sticky error code.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Sequencing: flush, marker probe with length check, then bit load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
            err_d   = ERR_NONE;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == LAST_C) begin
            state_d = ST_PROBE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        ST_PROBE: begin
          if (cnt_q < LEN_C) begin
            cnt_d = cnt_q + ONE_C;
            // Marker seen before CHAIN_LEN shifts: the chain is too short.
            if ((cnt_q != '0) && ccff_tail) begin
              state_d = ST_ERROR;
              err_d   = ERR_SHORT;
            end
          end else if (ccff_tail) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_LONG;
          end
        end
        ST_LOAD: begin
          if (ser_bit_valid) begin
            cnt_d = cnt_q + ONE_C;
            if (cnt_q == LAST_C) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Chain drive and status; head is forced low whenever the chain holds.
  always_comb begin
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    err_code      = err_q;
    unique case (state_q)
      ST_FLUSH: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
      end
      ST_PROBE: begin
        busy          = 1'b1;
        ccff_shift_en = (cnt_q < LEN_C);
        ccff_head     = (cnt_q < LEN_C) && (cnt_q == '0);
      end
      ST_LOAD: begin
        busy          = 1'b1;
        ccff_shift_en = ser_bit_valid;
        ccff_head     = ser_bit_valid & ser_bit;
      end
      ST_DONE:  done  = 1'b1;
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural shift-register chain of
// selectable length, a word feeder with programmable gaps, and directed runs.
module tb_ccff_chain_loader;

  localparam int N_MAX = 64;
  // Words A5,3C,FF,01 as a 32-bit stream 0x01FF3CA5 (bit0 first);
  // bit j lands in flop 31-j, i.e. the bit-reversed stream.
  localparam logic [31:0] EXP_CHAIN = 32'hA53CFF80;

  logic       prog_clk = 1'b0;
  logic       prog_reset, start, abort, s_valid, s_ready;
  logic [7:0] s_data;
  logic       ccff_head, ccff_shift_en, ccff_tail;
  logic       busy, done, error;
  logic [1:0] err_code;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .start         (start),
    .abort         (abort),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code)
  );

  // Chain model
  logic [N_MAX-1:0] chain = '0;
  int model_n = 32;
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[N_MAX-2:0], ccff_head};
  always_comb ccff_tail = chain[model_n-1];

  // Observers
  int   shift_total = 0, acc_total = 0, head_viol = 0;
  logic hs_q = 1'b0;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) shift_total <= shift_total + 1;
    if (!ccff_shift_en && ccff_head) head_viol <= head_viol + 1;
    hs_q <= s_valid && s_ready;
    if (s_valid && s_ready) acc_total <= acc_total + 1;
  end

  // Word feeder
  logic [7:0] words [4];
  logic feed_en = 1'b0;
  int   feed_gap = 0, feed_idx = 0, gap_left = 0;
  initial begin
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(posedge prog_clk); #1;
      if (!feed_en) begin
        s_valid = 1'b0; feed_idx = 0; gap_left = 0;
      end else begin
        if (s_valid && hs_q) begin
          feed_idx = feed_idx + 1; s_valid = 1'b0; gap_left = feed_gap;
        end
        if (!s_valid && feed_idx < 4) begin
          if (gap_left > 0) gap_left = gap_left - 1;
          else begin s_valid = 1'b1; s_data = words[feed_idx]; end
        end
      end
    end
  end

  int checks = 0, errors = 0;
  int sh0, ac0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk); #1;
  endtask

  task automatic start_run(input int n, input int gap);
    feed_en = 1'b0;
    tick(); tick();
    model_n  = n;
    feed_gap = gap;
    feed_en  = 1'b1;
    sh0 = shift_total;
    ac0 = acc_total;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    while (!(done || error) && lat < 2000) begin tick(); lat++; end
    if (lat >= 2000) begin
      checks++; errors++;
      $display("FAIL end_timeout: got no done/error after %0d cycles", lat);
    end
  endtask

  task automatic wait_load_bits(input int bits);
    int k = 0;
    while ((shift_total - sh0) < 64 + bits && k < 500) begin tick(); k++; end
    chk("reach_load_bit", 64'(shift_total - sh0), 64'(64 + bits));
  endtask

  typedef struct {
    int         n;
    int         gap;
    logic       exp_done;
    logic       exp_err;
    logic [1:0] exp_code;
    int         exp_lat;
    int         exp_shifts;
    int         exp_words;
  } vec_t;

  vec_t vt[6];
  int lat, lat2, sh1;

  initial begin
    vt[0] = '{32, 0,  1'b1, 1'b0, 2'b00, 98,  96, 4};
    vt[1] = '{31, 0,  1'b0, 1'b1, 2'b01, 64,  64, 0};
    vt[2] = '{33, 0,  1'b0, 1'b1, 2'b10, 65,  64, 0};
    vt[3] = '{32, 0,  1'b1, 1'b0, 2'b00, 98,  96, 4};
    vt[4] = '{32, 5,  1'b1, 1'b0, 2'b00, 98,  96, 4};
    vt[5] = '{32, 12, 1'b1, 1'b0, 2'b00, 113, 96, 4};

    prog_reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_s_ready", s_ready, 0);
    prog_reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      start_run(vt[i].n, vt[i].gap);
      wait_end(lat);
      chk($sformatf("v%0d_done", i), done, vt[i].exp_done);
      chk($sformatf("v%0d_error", i), error, vt[i].exp_err);
      chk($sformatf("v%0d_err_code", i), err_code, vt[i].exp_code);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("v%0d_shifts", i), 64'(shift_total - sh0), 64'(vt[i].exp_shifts));
      chk($sformatf("v%0d_words", i), 64'(acc_total - ac0), 64'(vt[i].exp_words));
      if (vt[i].exp_done) chk($sformatf("v%0d_chain", i), chain[31:0], EXP_CHAIN);
      repeat (3) tick();
      chk($sformatf("v%0d_hold", i), {done, error, err_code}, {vt[i].exp_done, vt[i].exp_err, vt[i].exp_code});
      chk($sformatf("v%0d_hold_shifts", i), 64'(shift_total - sh0), 64'(vt[i].exp_shifts));
    end

    // start while busy is ignored
    start_run(32, 0);
    repeat (10) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_end(lat2);
    chk("busy_start_latency", 64'(11 + lat2), 64'd98);
    chk("busy_start_done", done, 1);
    chk("busy_start_chain", chain[31:0], EXP_CHAIN);

    // start+abort together in DONE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    sh1 = shift_total;
    chk("sa_done", done, 0);
    chk("sa_busy", busy, 0);
    repeat (5) tick();
    chk("sa_no_shift", 64'(shift_total - sh1), 0);
    chk("sa_idle", {busy, done, error}, 0);

    // abort at LOAD bit 12
    start_run(32, 0);
    wait_load_bits(12);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_shift_en", ccff_shift_en, 0);
    chk("abort_done", done, 0);
    chk("abort_s_ready", s_ready, 0);
    sh1 = shift_total;
    repeat (4) tick();
    chk("abort_no_shift", 64'(shift_total - sh1), 0);

    // prog_reset mid-LOAD
    start_run(32, 0);
    wait_load_bits(12);
    prog_reset = 1'b1; tick(); prog_reset = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_shift_en", ccff_shift_en, 0);
    chk("mrst_done", done, 0);
    chk("mrst_s_ready", s_ready, 0);
    chk("mrst_err_code", err_code, 0);

    // a clean load afterwards
    start_run(32, 0);
    wait_end(lat);
    chk("after_done", done, 1);
    chk("after_latency", 64'(lat), 64'd98);
    chk("after_chain", chain[31:0], EXP_CHAIN);
    chk("head_gated", 64'(head_viol), 0);

    feed_en = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
